sram_arb: RTL and testbench



---
 rtl/sram_arb_pkg.sv | 15 +
 rtl/sram_arb_idfifo.sv | 60 ++++++
 rtl/sram_arb.sv | 162 ++++++++++++++++
 tb/tb_sram_arb.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared constants for the three-master SRAM arbiter.
// Master IDs double as the tags held in the read-return FIFO.
package sram_arb_pkg;

    localparam int AW = 18;
    localparam int DW = 32;

    localparam int RD_DEPTH_DEF  = 4;
    localparam int VGA_LIMIT_DEF = 8;

    localparam logic [1:0] M_VGA  = 2'd0;
    localparam logic [1:0] M_IMEM = 2'd1;
    localparam logic [1:0] M_DMEM = 2'd2;

endpackage

// File: rtl/sram_arb_idfifo.sv
// Read-return ID FIFO: remembers which master owns each outstanding read.
// A push into a full FIFO is allowed when a pop happens in the same cycle.
module sram_arb_idfifo
    import sram_arb_pkg::*;
#(
    parameter int DEPTH = RD_DEPTH_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [1:0] wdata_i,
    output logic [1:0] rdata_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] P_ONE = PW'(1);
    localparam logic [PW:0] C_ONE = (PW + 1)'(1);
    localparam logic [PW:0] C_FULL = (PW + 1)'(DEPTH);

    logic [1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW:0] cnt_q, cnt_d;
    logic do_push, do_pop;

    assign full_o  = (cnt_q == C_FULL);
    assign empty_o = (cnt_q == '0);
    assign rdata_o = mem_q[rd_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_d  = do_push ? wr_q + P_ONE : wr_q;
        rd_d  = do_pop ? rd_q + P_ONE : rd_q;
        cnt_d = cnt_q;
        if (do_push & ~do_pop) cnt_d = cnt_q + C_ONE;
        else if (do_pop & ~do_push) cnt_d = cnt_q - C_ONE;
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sram_arb.sv
// Zero-latency arbiter: VGA (m0) first, imem/dmem round-robin,
// with a starvation guard and in-order read-return steering.
module sram_arb
    import sram_arb_pkg::*;
#(
    parameter int RD_DEPTH  = RD_DEPTH_DEF,
    parameter int VGA_LIMIT = VGA_LIMIT_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] m0_addr,
    input  logic          m0_rd,
    input  logic          m0_wr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [3:0]    m0_be,
    output logic          m0_wait,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_rvalid,
    input  logic [AW-1:0] m1_addr,
    input  logic          m1_rd,
    input  logic          m1_wr,
    input  logic [DW-1:0] m1_wdata,
    input  logic [3:0]    m1_be,
    output logic          m1_wait,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_rvalid,
    input  logic [AW-1:0] m2_addr,
    input  logic          m2_rd,
    input  logic          m2_wr,
    input  logic [DW-1:0] m2_wdata,
    input  logic [3:0]    m2_be,
    output logic          m2_wait,
    output logic [DW-1:0] m2_rdata,
    output logic          m2_rvalid,
    output logic [AW-1:0] t_addr,
    output logic          t_rd,
    output logic          t_wr,
    output logic [DW-1:0] t_wdata,
    output logic [3:0]    t_be,
    input  logic          t_wait,
    input  logic [DW-1:0] t_rdata,
    input  logic          t_rvalid,
    output logic          err
);

    localparam int CW = $clog2(VGA_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(VGA_LIMIT);
    localparam logic [CW-1:0] C_ONE = CW'(1);

    logic [2:0] rd, wr, req, ok, lo, gnt, acc;
    logic starve, can_push, pop, push, full, empty, rvld;
    logic [1:0] push_id, head_id;
    logic rr_q, rr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic err_q, err_d;

    assign rd  = {m2_rd, m1_rd, m0_rd};
    assign wr  = {m2_wr, m1_wr, m0_wr};
    assign req = rd | wr;

    // A read may go out when a slot is free or one frees this same cycle.
    assign pop      = t_rvalid & ~empty;
    assign can_push = ~full | pop;
    assign ok       = wr | (rd & {3{can_push}});

    always_comb begin
        lo = {ok[2], ok[1], 1'b0};
        if (ok[1] & ok[2]) lo = rr_q ? 3'b100 : 3'b010;
    end

    assign starve = (cnt_q == LIM) & (|lo);

    always_comb begin
        gnt = 3'b000;
        if (rst_n) begin
            if (ok[0] & ~starve) gnt = 3'b001;
            else gnt = lo;
        end
    end

    assign acc = gnt & {3{~t_wait}};
    assign {m2_wait, m1_wait, m0_wait} = req & ~acc;

    always_comb begin
        t_addr  = '0;
        t_rd    = 1'b0;
        t_wr    = 1'b0;
        t_wdata = '0;
        t_be    = '0;
        unique case (1'b1)
            gnt[0]: begin
                t_addr  = m0_addr;
                t_rd    = m0_rd;
                t_wr    = m0_wr;
                t_wdata = m0_wdata;
                t_be    = m0_be;
            end
            gnt[1]: begin
                t_addr  = m1_addr;
                t_rd    = m1_rd;
                t_wr    = m1_wr;
                t_wdata = m1_wdata;
                t_be    = m1_be;
            end
            gnt[2]: begin
                t_addr  = m2_addr;
                t_rd    = m2_rd;
                t_wr    = m2_wr;
                t_wdata = m2_wdata;
                t_be    = m2_be;
            end
            default: ;
        endcase
    end

    assign push    = |(acc & rd);
    assign push_id = acc[2] ? M_DMEM : (acc[1] ? M_IMEM : M_VGA);

    sram_arb_idfifo #(
        .DEPTH (RD_DEPTH)
    ) u_idfifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (push_id),
        .rdata_o (head_id),
        .full_o  (full),
        .empty_o (empty)
    );

    assign rvld      = pop & rst_n;
    assign m0_rvalid = rvld & (head_id == M_VGA);
    assign m1_rvalid = rvld & (head_id == M_IMEM);
    assign m2_rvalid = rvld & (head_id == M_DMEM);
    assign m0_rdata  = t_rdata;
    assign m1_rdata  = t_rdata;
    assign m2_rdata  = t_rdata;
    assign err       = err_q;

    always_comb begin
        cnt_d = cnt_q;
        if ((|acc[2:1]) | ~(req[1] | req[2])) cnt_d = '0;
        else if (acc[0] & (cnt_q != LIM)) cnt_d = cnt_q + C_ONE;
    end

    assign rr_d  = rr_q ^ (|acc[2:1]);
    assign err_d = err_q | (t_rvalid & empty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q  <= 1'b0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            rr_q  <= rr_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_sram_arb.sv
// Randomised and directed bench for sram_arb against a queue-based
// model of grant priority, starvation guard and read-return order.
module tb_sram_arb;

    localparam int DEPTH = 4;
    localparam int LIM   = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [17:0] a [3];
    logic        rd [3];
    logic        wr [3];
    logic [31:0] wd [3];
    logic [3:0]  be [3];
    logic        w [3];
    logic        rv [3];
    logic [31:0] rdat [3];
    logic [17:0] t_addr;
    logic        t_rd, t_wr;
    logic [31:0] t_wdata;
    logic [3:0]  t_be;
    logic        t_wait, t_rvalid;
    logic [31:0] t_rdata;
    logic        err;

    sram_arb dut (
        .clk(clk), .rst_n(rst_n),
        .m0_addr(a[0]), .m0_rd(rd[0]), .m0_wr(wr[0]), .m0_wdata(wd[0]),
        .m0_be(be[0]), .m0_wait(w[0]), .m0_rdata(rdat[0]), .m0_rvalid(rv[0]),
        .m1_addr(a[1]), .m1_rd(rd[1]), .m1_wr(wr[1]), .m1_wdata(wd[1]),
        .m1_be(be[1]), .m1_wait(w[1]), .m1_rdata(rdat[1]), .m1_rvalid(rv[1]),
        .m2_addr(a[2]), .m2_rd(rd[2]), .m2_wr(wr[2]), .m2_wdata(wd[2]),
        .m2_be(be[2]), .m2_wait(w[2]), .m2_rdata(rdat[2]), .m2_rvalid(rv[2]),
        .t_addr(t_addr), .t_rd(t_rd), .t_wr(t_wr), .t_wdata(t_wdata),
        .t_be(t_be), .t_wait(t_wait), .t_rdata(t_rdata),
        .t_rvalid(t_rvalid), .err(err)
    );

    int total = 0;
    int bad = 0;

    int idq [$];
    int cnt;
    int rr;
    bit m_err;
    bit [1:0] pipe;
    bit auto_ret = 0;
    int grants [$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        idq.delete();
        cnt = 0;
        rr = 1;
        m_err = 0;
        pipe = 2'b00;
    endtask

    task automatic set_idle();
        for (int n = 0; n < 3; n++) begin
            a[n] = 18'(n * 16'h111);
            rd[n] = 0;
            wr[n] = 0;
            wd[n] = 32'hA000_0000 + n;
            be[n] = 4'hF;
        end
        t_wait = 0;
        t_rvalid = 0;
        t_rdata = 32'h0;
    endtask

    // Entered just after a falling edge with inputs already applied.
    task automatic cycle();
        bit req [3];
        bit ok [3];
        bit acc, pop, cpush;
        int pick, g, gobs;
        if (auto_ret) t_rvalid = pipe[1];
        t_rdata = $urandom;
        #2;
        for (int n = 0; n < 3; n++) req[n] = rd[n] | wr[n];
        pop = t_rvalid && idq.size() > 0;
        cpush = idq.size() < DEPTH || pop;
        for (int n = 0; n < 3; n++) ok[n] = wr[n] || (rd[n] && cpush);
        pick = -1;
        if (ok[1] && ok[2]) pick = rr;
        else if (ok[1]) pick = 1;
        else if (ok[2]) pick = 2;
        g = -1;
        if (rst_n) begin
            if (ok[0] && !(cnt == LIM && pick > 0)) g = 0;
            else g = pick;
        end
        acc = g >= 0 && !t_wait;
        for (int n = 0; n < 3; n++) begin
            chk($sformatf("wait%0d", n), 32'(w[n]),
                32'(req[n] && !(acc && g == n)));
            chk($sformatf("rvalid%0d", n), 32'(rv[n]),
                32'(rst_n && pop && idq[0] == n));
            chk($sformatf("rdata%0d", n), rdat[n], t_rdata);
        end
        chk("t_rd", 32'(t_rd), 32'(g >= 0 ? rd[g] : 1'b0));
        chk("t_wr", 32'(t_wr), 32'(g >= 0 ? wr[g] : 1'b0));
        if (g >= 0) begin
            chk("t_addr", 32'(t_addr), 32'(a[g]));
            chk("t_wdata", t_wdata, wd[g]);
            chk("t_be", 32'(t_be), 32'(be[g]));
        end
        chk("err", 32'(err), 32'(rst_n ? m_err : 1'b0));
        gobs = -1;
        for (int n = 0; n < 3; n++)
            if (rst_n && (rd[n] || wr[n]) && !w[n]) gobs = n;
        if (gobs >= 0) grants.push_back(gobs);
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (t_rvalid) begin
                if (idq.size() > 0) void'(idq.pop_front());
                else m_err = 1;
            end
            if (acc && rd[g]) idq.push_back(g);
            if (acc && g > 0) cnt = 0;
            else if (!(req[1] || req[2])) cnt = 0;
            else if (acc && g == 0 && cnt < LIM) cnt++;
            if (acc && g > 0) rr = (rr == 1) ? 2 : 1;
            pipe = {pipe[0], acc && rd[g]};
        end
        @(negedge clk);
    endtask

    task automatic reset_dut();
        set_idle();
        auto_ret = 0;
        rst_n = 0;
        cycle();
        cycle();
        rst_n = 1;
        grants.delete();
    endtask

    int exp033 [18];
    int exp034 [6];

    initial begin
        set_idle();
        model_reset();
        @(negedge clk);
        rst_n = 0;
        rd[1] = 1;
        #1;
        chk("reset_wait1", 32'(w[1]), 32'd1);
        chk("reset_trd", 32'(t_rd), 32'd0);
        cycle();
        rst_n = 1;
        set_idle();
        cycle();

        // All three read continuously, two-cycle return latency.
        reset_dut();
        auto_ret = 1;
        for (int n = 0; n < 3; n++) rd[n] = 1;
        repeat (24) cycle();
        for (int i = 0; i < 18; i++) exp033[i] = 0;
        exp033[8] = 1;
        exp033[17] = 2;
        chk("req033_n", 32'(grants.size() >= 18), 32'd1);
        for (int i = 0; i < 18; i++)
            chk($sformatf("req033_g%0d", i),
                32'(grants.size() > i ? grants[i] : -1), 32'(exp033[i]));
        auto_ret = 0;
        set_idle();
        repeat (4) cycle();

        // Writers only: strict alternation from m1.
        reset_dut();
        wr[1] = 1;
        wr[2] = 1;
        repeat (6) cycle();
        exp034 = '{1, 2, 1, 2, 1, 2};
        for (int i = 0; i < 6; i++)
            chk($sformatf("req034_g%0d", i),
                32'(grants.size() > i ? grants[i] : -1), 32'(exp034[i]));

        // Full FIFO stalls the read but lets a write through.
        reset_dut();
        rd[2] = 1;
        repeat (4) cycle();
        wr[1] = 1;
        #1;
        chk("req035_m2_stall", 32'(w[2]), 32'd1);
        chk("req035_m1_write", 32'(w[1]), 32'd0);
        cycle();
        wr[1] = 0;
        rd[2] = 0;
        t_rvalid = 1;
        cycle();
        t_rvalid = 0;
        rd[2] = 1;
        #1;
        chk("req035_fifth", 32'(w[2]), 32'd0);
        cycle();
        set_idle();
        t_rvalid = 1;
        repeat (4) cycle();

        // Simultaneous push and pop at full occupancy.
        reset_dut();
        rd[2] = 1;
        repeat (4) cycle();
        rd[2] = 0;
        rd[1] = 1;
        t_rvalid = 1;
        #1;
        chk("req036_no_stall", 32'(w[1]), 32'd0);
        chk("req036_route", 32'(rv[2]), 32'd1);
        cycle();
        t_rvalid = 0;
        #1;
        chk("req036_still_full", 32'(w[1]), 32'd1);
        cycle();
        set_idle();
        t_rvalid = 1;
        repeat (4) cycle();

        // Return with nothing outstanding.
        reset_dut();
        t_rvalid = 1;
        cycle();
        t_rvalid = 0;
        #1;
        chk("req037_err", 32'(err), 32'd1);
        repeat (3) cycle();
        rst_n = 0;
        #1;
        chk("req037_clr", 32'(err), 32'd0);
        cycle();
        rst_n = 1;

        // Asynchronous reset with reads in flight.
        reset_dut();
        rd[1] = 1;
        repeat (3) cycle();
        rd[0] = 1;
        t_rvalid = 1;
        #1;
        chk("req038_pre_trd", 32'(t_rd), 32'd1);
        rst_n = 0;
        #1;
        chk("req038_trd", 32'(t_rd), 32'd0);
        chk("req038_w0", 32'(w[0]), 32'd1);
        chk("req038_w1", 32'(w[1]), 32'd1);
        for (int n = 0; n < 3; n++)
            chk($sformatf("req038_rv%0d", n), 32'(rv[n]), 32'd0);
        @(negedge clk);
        model_reset();
        set_idle();
        cycle();
        rst_n = 1;
        rd[1] = 1;
        rd[2] = 1;
        #1;
        chk("req038_first_m1", 32'(w[1]), 32'd0);
        chk("req038_m2_waits", 32'(w[2]), 32'd1);
        cycle();
        set_idle();
        t_rvalid = 1;
        repeat (3) cycle();

        // Random traffic against the model.
        reset_dut();
        for (int i = 0; i < 3000; i++) begin
            for (int n = 0; n < 3; n++) begin
                int r;
                r = $urandom_range(0, 5);
                rd[n] = (r == 1 || r == 2 || (n == 0 && r == 5));
                wr[n] = (r == 3);
                a[n] = 18'($urandom);
                wd[n] = $urandom;
                be[n] = 4'($urandom);
            end
            t_wait = ($urandom_range(0, 4) == 0);
            t_rvalid = (idq.size() > 0) && ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
